// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants for the 4-digit multiplexed display scanner
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_NONE = 4'b1111;

  // Segment patterns for nibbles 0..F, bit 0 = segment a, bit 6 = segment g
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational nibble to seven-segment glyph lookup
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  assign segs = GLYPH_TABLE[nibble];

endmodule

// File: rtl/display_scan_4d.sv
// rtl/display_scan_4d.sv - 4-digit scanned LED driver with double-buffered digits
module display_scan_4d
  import display_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  input  logic        blank_all,
  output logic        load_ack,
  output logic [7:0]  segmentos,
  output logic [3:0]  sel_seg
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0]      presc_cnt;
  logic [1:0]            digit_idx;
  logic [15:0]           active_digits;
  logic [15:0]           pending_digits;
  logic [3:0]            active_dp;
  logic [3:0]            pending_dp;
  logic                  pending_valid;
  logic                  tick;
  logic                  frame_wrap;
  logic [3:0]            cur_nibble;
  logic [6:0]            cur_glyph;
  logic                  z3, z2, z1;
  logic [NUM_DIGITS-1:0] lz_mask;

  assign tick       = (presc_cnt == CNT_LAST);
  assign frame_wrap = tick && (digit_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
      digit_idx <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) begin
        digit_idx <= digit_idx + 2'd1;
      end
    end
  end

  // New data only reaches the display at a frame boundary so a frame never mixes two values
  always_ff @(posedge clk) begin
    if (rst) begin
      active_digits  <= '0;
      active_dp      <= '0;
      pending_digits <= '0;
      pending_dp     <= '0;
      pending_valid  <= 1'b0;
      load_ack       <= 1'b0;
    end else begin
      load_ack <= 1'b0;
      if (frame_wrap && pending_valid) begin
        active_digits <= pending_digits;
        active_dp     <= pending_dp;
        pending_valid <= 1'b0;
        load_ack      <= 1'b1;
      end
      if (load) begin
        pending_digits <= digits_in;
        pending_dp     <= dp_in;
        pending_valid  <= 1'b1;
      end
    end
  end

  assign z3 = (active_digits[15:12] == 4'd0);
  assign z2 = (active_digits[11:8] == 4'd0);
  assign z1 = (active_digits[7:4] == 4'd0);
  // A digit goes dark only when it and every digit to its left are zero; digit 0 always shows
  assign lz_mask = {blank_lz & z3, blank_lz & z3 & z2, blank_lz & z3 & z2 & z1, 1'b0};

  assign cur_nibble = active_digits[{digit_idx, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble (cur_nibble),
    .segs   (cur_glyph)
  );

  always_ff @(posedge clk) begin
    if (rst || blank_all) begin
      segmentos <= SEG_OFF;
      sel_seg   <= SEL_NONE;
    end else begin
      segmentos <= {active_dp[digit_idx], lz_mask[digit_idx] ? 7'd0 : cur_glyph};
      sel_seg   <= ~(NUM_DIGITS'(1) << digit_idx);
    end
  end

endmodule
